// File: rtl/cla_seq_arbiter_if.sv
// Bundle of request, response and shared-adder signals for cla_seq_arbiter.
// The arbiter uses the slave modport; requesters, consumer and adder sit on the master side.
`timescale 1ns/1ps
interface cla_seq_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_id;
  logic [CHUNK-1:0] add_a;
  logic [CHUNK-1:0] add_b;
  logic             add_cin;
  logic [CHUNK-1:0] add_sum;
  logic             add_cout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  rsp_ready, add_sum, add_cout,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id,
    output add_a, add_b, add_cin
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output rsp_ready, add_sum, add_cout,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id,
    input  add_a, add_b, add_cin
  );
endinterface

// File: rtl/cla_seq_arbiter.sv
// Round-robin arbiter time-sharing one external CHUNK-bit CLA adder between two requesters;
// a WIDTH-bit add runs as WIDTH/CHUNK sequential chunk adds chained through a registered carry.
`timescale 1ns/1ps
module cla_seq_arbiter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_seq_arbiter_if.slave   bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_width
    $error("cla_seq_arbiter: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_last_grant;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_cout;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_id;

  logic             w_grant_vld;
  logic             w_grant_id;
  logic [CHUNK-1:0] w_chunk_a;
  logic [CHUNK-1:0] w_chunk_b;
  logic [WIDTH-1:0] w_sum_next;

  // Round-robin: a tie goes to the requester not served last.
  always_comb begin
    w_grant_vld = rst_n && (r_state == IDLE) && (bus.req0_valid || bus.req1_valid);
    w_grant_id  = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
  end

  always_comb begin
    w_chunk_a  = '0;
    w_chunk_b  = '0;
    w_sum_next = r_sum;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_chunk_a                    = r_a[k*CHUNK +: CHUNK];
        w_chunk_b                    = r_b[k*CHUNK +: CHUNK];
        w_sum_next[k*CHUNK +: CHUNK] = bus.add_sum;
      end
    end
  end

  assign bus.req0_ready = w_grant_vld & ~w_grant_id;
  assign bus.req1_ready = w_grant_vld &  w_grant_id;
  assign bus.add_a      = (r_state == RUN) ? w_chunk_a : '0;
  assign bus.add_b      = (r_state == RUN) ? w_chunk_b : '0;
  assign bus.add_cin    = (r_state == RUN) ? ((r_idx == '0) ? r_cin : r_carry) : 1'b0;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_sum    = r_rsp_sum;
  assign bus.rsp_cout   = r_rsp_cout;
  assign bus.rsp_id     = r_rsp_id;

  // Operand capture needs no reset: it is only read after an accept has loaded it.
  always_ff @(posedge clk) begin
    if (w_grant_vld) begin
      r_a   <= w_grant_id ? bus.req1_a   : bus.req0_a;
      r_b   <= w_grant_id ? bus.req1_b   : bus.req0_b;
      r_cin <= w_grant_id ? bus.req1_cin : bus.req0_cin;
      r_id  <= w_grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_sum        <= '0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_sum    <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_id     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_last_grant <= w_grant_id;
            r_idx        <= '0;
            r_state      <= RUN;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= bus.add_cout;
          r_idx   <= r_idx + 1'b1;
          // The final chunk's sum and carry go straight into the response registers.
          if (r_idx == LAST_IDX) begin
            r_state     <= DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_sum_next;
            r_rsp_cout  <= bus.add_cout;
            r_rsp_id    <= r_id;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_arbiter.sv
// Scoreboard bench for cla_seq_arbiter: an ideal adder on the shared port, a latency/arbitration
// model predicting grants, and a negedge monitor comparing every response against the queue.
`timescale 1ns/1ps
module tb_cla_seq_arbiter;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct packed {
    logic             id;
    logic             cout;
    logic [WIDTH-1:0] sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_seq_arbiter_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) bus ();
  cla_seq_arbiter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{CHUNK{1'b0}}, bus.add_cin};

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q[$];
  int   m_state = 0;   // 0 waiting for a request, 1 adding, 2 result pending
  int   m_cnt   = 0;
  logic m_last  = 1'b1;
  int   n_acc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready(input logic which);
    logic g;
    if (!rst_n || m_state != 0) return 1'b0;
    if (!bus.req0_valid && !bus.req1_valid) return 1'b0;
    g = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
    return g == which;
  endfunction

  // Reference: accept per round-robin rule, result = a+b+cin, valid NCHUNK edges later.
  always @(posedge clk or negedge rst_n) begin
    logic             gid;
    logic [WIDTH:0]   full;
    exp_t             e;
    if (!rst_n) begin
      m_state = 0;
      m_cnt   = 0;
      m_last  = 1'b1;
      q.delete();
    end else begin
      case (m_state)
        0: if (bus.req0_valid || bus.req1_valid) begin
             gid  = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
             full = gid ? ({1'b0, bus.req1_a} + {1'b0, bus.req1_b} + (WIDTH+1)'(bus.req1_cin))
                        : ({1'b0, bus.req0_a} + {1'b0, bus.req0_b} + (WIDTH+1)'(bus.req0_cin));
             e.id   = gid;
             e.cout = full[WIDTH];
             e.sum  = full[WIDTH-1:0];
             q.push_back(e);
             m_last  = gid;
             m_state = 1;
             m_cnt   = NCHUNK;
             n_acc++;
           end
        1: begin
             m_cnt--;
             if (m_cnt == 0) m_state = 2;
           end
        default: if (bus.rsp_ready) m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_state == 2));
      chk("req0_ready", 64'(bus.req0_ready), 64'(exp_ready(1'b0)));
      chk("req1_ready", 64'(bus.req1_ready), 64'(exp_ready(1'b1)));
      if (m_state != 1)
        chk("add_idle", 64'({bus.add_a, bus.add_b, bus.add_cin}), 64'(0));
      if (bus.rsp_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
        end else begin
          chk("rsp_sum", 64'(bus.rsp_sum), 64'(q[0].sum));
          chk("rsp_cout", 64'(bus.rsp_cout), 64'(q[0].cout));
          chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
          if (bus.rsp_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_rsp_sum"}, 64'(bus.rsp_sum), 64'(0));
    chk({tag, "_rsp_cout_id"}, 64'({bus.rsp_cout, bus.rsp_id}), 64'(0));
    chk({tag, "_ready"}, 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
    chk({tag, "_adder"}, 64'({bus.add_a, bus.add_b, bus.add_cin}), 64'(0));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set0(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c;
  endtask

  task automatic set1(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = c;
  endtask

  // Wait for n model accepts; with drop, the accepted requester withdraws its valid.
  task automatic run_ops(input int n, input bit drop, input int budget);
    int start = n_acc;
    int cyc   = 0;
    int prev;
    while ((n_acc - start) < n && cyc < budget) begin
      prev = n_acc;
      step();
      cyc++;
      if (drop && n_acc != prev) begin
        if (m_last) bus.req1_valid = 1'b0;
        else        bus.req0_valid = 1'b0;
      end
    end
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    while ((q.size() != 0 || m_state != 0) && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "_drain"}, 64'(q.size()), 64'(0));
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return WIDTH'(32'h0000_FFFF);
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    set0(1'b0, '0, '0, 1'b0);
    set1(1'b0, '0, '0, 1'b0);
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step();
    set0(1'b1, 32'd1, 32'd2, 1'b0);
    set1(1'b1, 32'd3, 32'd4, 1'b0);
    #1 check_reset("por");

    // Tie in the first cycle after reset: req0 first, then req1.
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    run_ops(2, 1'b1, 50);
    drain("tie");

    set0(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    run_ops(1, 1'b1, 20);
    drain("chunk_carry");

    set1(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    run_ops(1, 1'b1, 20);
    drain("full_carry");

    set0(1'b1, rnd_word(), rnd_word(), 1'b1);
    set1(1'b1, rnd_word(), rnd_word(), 1'b0);
    run_ops(6, 1'b0, 100);
    drain("continuous");

    // Backpressure: consumer stalls while req1 waits.
    bus.rsp_ready = 1'b0;
    set0(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b1);
    run_ops(1, 1'b1, 20);
    set1(1'b1, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    repeat (NCHUNK + 5) step();
    bus.rsp_ready = 1'b1;
    run_ops(1, 1'b1, 20);
    drain("backpressure");

    // Reset while the second chunk is in flight.
    set0(1'b1, 32'hAAAA_FFFF, 32'h5555_0001, 1'b0);
    run_ops(1, 1'b1, 20);
    step();
    rst_n = 1'b0;
    set0(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0);
    set1(1'b1, 32'h0000_0030, 32'h0000_0040, 1'b1);
    #1 check_reset("mid_run");
    step();
    rst_n = 1'b1;
    run_ops(2, 1'b1, 50);
    drain("after_reset");

    for (int i = 0; i < 400; i++) begin
      set0(1'($urandom_range(0, 1)), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
      set1(1'($urandom_range(0, 1)), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
